// File: rtl/ddr_app_responder.sv
// BRAM-backed stand-in for the MIG DDR2 app_* responder: calibration delay, command/write-data
// backpressure, write-data FIFO that pairs with write commands in order, and fixed-latency reads.
module ddr_app_responder #(
    parameter int ADDR_W       = 27,
    parameter int DATA_W       = 128,
    parameter int MEM_AW       = 10,
    parameter int WDF_DEPTH    = 4,
    parameter int RD_LATENCY   = 4,
    parameter int CALIB_CYCLES = 64,
    parameter int STALL_PERIOD = 0
) (
    input  logic                  ui_clk_i,
    input  logic                  ui_rst_i,
    input  logic [ADDR_W-1:0]     app_addr,
    input  logic [2:0]            app_cmd,
    input  logic                  app_en,
    input  logic [DATA_W-1:0]     app_wdf_data,
    input  logic                  app_wdf_wren,
    input  logic                  app_wdf_end,
    input  logic [DATA_W/8-1:0]   app_wdf_mask,
    output logic                  app_rdy,
    output logic                  app_wdf_rdy,
    output logic [DATA_W-1:0]     app_rd_data,
    output logic                  app_rd_data_valid,
    output logic                  app_rd_data_end,
    output logic                  init_calib_complete,
    output logic                  err_o
);
    localparam int MW         = DATA_W / 8;
    localparam int PW         = $clog2(WDF_DEPTH);
    localparam int CW         = $clog2(CALIB_CYCLES + 1);
    localparam int SW         = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam int STALL_LAST = (STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0;

    logic [DATA_W-1:0] mem [2**MEM_AW];
    logic [DATA_W-1:0] wdf_data_q [WDF_DEPTH];
    logic [MW-1:0]     wdf_mask_q [WDF_DEPTH];
    logic [PW:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]     calib_cnt;
    logic [SW-1:0]     stall_cnt;
    logic              calib, stall, pend_wr;
    logic [MEM_AW-1:0] pend_idx, cmd_idx, commit_idx;
    logic [DATA_W-1:0] commit_data;
    logic [MW-1:0]     commit_mask;
    logic              fifo_empty, fifo_full, push, store, pop, commit, data_avail;
    logic              cmd_acc, wr_acc, rd_acc, bad_cmd, proto_err;
    logic [DATA_W-1:0] rd_data_p [RD_LATENCY-1];
    logic              vld_p [RD_LATENCY-1];
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{app_addr[ADDR_W-1:MEM_AW+3], app_addr[2:0]};
    assign cmd_idx    = app_addr[MEM_AW+2:3];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign stall      = (STALL_PERIOD > 0) && (stall_cnt == SW'(STALL_LAST));

    assign app_rdy         = calib & ~pend_wr & ~stall;
    assign app_wdf_rdy     = calib & ~fifo_full;
    assign app_rd_data_end = app_rd_data_valid;
    assign init_calib_complete = calib;

    assign push    = app_wdf_wren & app_wdf_rdy;
    assign cmd_acc = app_en & app_rdy;
    assign wr_acc  = cmd_acc & (app_cmd == 3'b000);
    assign rd_acc  = cmd_acc & (app_cmd == 3'b001);
    assign bad_cmd = cmd_acc & (app_cmd[2:1] != 2'b00);

    // An empty FIFO with a beat arriving this cycle hands the beat straight to the commit.
    assign data_avail  = ~fifo_empty | push;
    assign commit      = (wr_acc | pend_wr) & data_avail;
    assign commit_data = fifo_empty ? app_wdf_data : wdf_data_q[rd_ptr[PW-1:0]];
    assign commit_mask = fifo_empty ? app_wdf_mask : wdf_mask_q[rd_ptr[PW-1:0]];
    assign commit_idx  = pend_wr ? pend_idx : cmd_idx;
    assign pop         = commit & ~fifo_empty;
    assign store       = push & ~(commit & fifo_empty);
    assign proto_err   = (app_wdf_wren & ~app_wdf_rdy) | (app_wdf_wren != app_wdf_end) | bad_cmd;

    always_ff @(posedge ui_clk_i) begin
        if (ui_rst_i) begin
            calib_cnt <= '0;
            calib     <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (!calib) begin
                calib_cnt <= calib_cnt + 1'b1;
                if (calib_cnt == CW'(CALIB_CYCLES - 1))
                    calib <= 1'b1;
            end
            if (STALL_PERIOD > 0)
                stall_cnt <= stall ? '0 : stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge ui_clk_i) begin
        if (ui_rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pend_wr <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            if (store)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_acc && !data_avail) begin
                pend_wr  <= 1'b1;
                pend_idx <= cmd_idx;
            end else if (pend_wr && data_avail) begin
                pend_wr <= 1'b0;
            end
            if (proto_err)
                err_o <= 1'b1;
        end
    end

    always_ff @(posedge ui_clk_i) begin
        if (store) begin
            wdf_data_q[wr_ptr[PW-1:0]] <= app_wdf_data;
            wdf_mask_q[wr_ptr[PW-1:0]] <= app_wdf_mask;
        end
    end

    // p0: registered BRAM read; byte-masked write commit
    always_ff @(posedge ui_clk_i) begin
        rd_data_p[0] <= mem[cmd_idx];
        for (int i = 1; i < RD_LATENCY - 1; i++)
            rd_data_p[i] <= rd_data_p[i-1];
        if (commit && !ui_rst_i) begin
            for (int b = 0; b < MW; b++)
                if (!commit_mask[b])
                    mem[commit_idx][b*8 +: 8] <= commit_data[b*8 +: 8];
        end
    end

    // p1..: read-latency delay line; output stage holds data while valid is low
    always_ff @(posedge ui_clk_i) begin
        if (ui_rst_i) begin
            for (int i = 0; i < RD_LATENCY - 1; i++)
                vld_p[i] <= 1'b0;
            app_rd_data_valid <= 1'b0;
            app_rd_data       <= '0;
        end else begin
            vld_p[0] <= rd_acc;
            for (int i = 1; i < RD_LATENCY - 1; i++)
                vld_p[i] <= vld_p[i-1];
            app_rd_data_valid <= vld_p[RD_LATENCY-2];
            if (vld_p[RD_LATENCY-2])
                app_rd_data <= rd_data_p[RD_LATENCY-2];
        end
    end
endmodule

// File: tb/tb_ddr_app_responder.sv
// Bench for ddr_app_responder: directed sequences, a table of masked-write vectors, and random
// traffic checked every cycle against a queue/array transaction model of the app_* protocol.
module tb_ddr_app_responder;
    localparam int ADDR_W = 27;
    localparam int DATA_W = 128;
    localparam int MEM_AW = 10;
    localparam int DEPTH  = 4;
    localparam int L      = 4;
    localparam int CALIB  = 20;
    localparam int STALL  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] app_addr = '0;
    logic [2:0]        app_cmd = '0;
    logic              app_en = 1'b0;
    logic [DATA_W-1:0] app_wdf_data = '0;
    logic              app_wdf_wren = 1'b0;
    logic              app_wdf_end = 1'b0;
    logic [15:0]       app_wdf_mask = '0;
    logic              app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end;
    logic              init_calib_complete, err_o;
    logic [DATA_W-1:0] app_rd_data;

    ddr_app_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW), .WDF_DEPTH(DEPTH),
        .RD_LATENCY(L), .CALIB_CYCLES(CALIB), .STALL_PERIOD(STALL)) dut (
        .ui_clk_i(clk), .ui_rst_i(rst), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_mask(app_wdf_mask), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end), .init_calib_complete(init_calib_complete), .err_o(err_o));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct { logic [127:0] d; logic [15:0] m; } wbeat_t;
    typedef struct { int due; logic [127:0] d; bit known; } rexp_t;

    logic [127:0] mem_m [1024];
    bit           known_m [1024];
    wbeat_t       wq[$];
    rexp_t        rq[$];
    int           since_rel = 0;
    bit           pend_m = 0;
    int           pend_idx_m = 0;
    bit           err_m = 0;
    bit           armed = 0;
    logic [127:0] last_d = '0;
    bit           last_k = 0;

    task automatic model_commit(input int idx);
        wbeat_t w;
        w = wq.pop_front();
        for (int b = 0; b < 16; b++)
            if (!w.m[b]) mem_m[idx][b*8 +: 8] = w.d[b*8 +: 8];
        known_m[idx] = known_m[idx] | (w.m == 16'h0);
    endtask

    always @(negedge clk) begin
        bit calib_m, rdy_m, wrdy_m, acc, push;
        int idx;
        rexp_t r;
        calib_m = (since_rel >= CALIB);
        rdy_m   = calib_m && !pend_m && ((since_rel % STALL) != STALL - 1);
        wrdy_m  = calib_m && (wq.size() < DEPTH);
        if (armed) begin
            if (rq.size() > 0 && rq[0].due == cyc) begin
                chk("mon_rd_valid", app_rd_data_valid, 1'b1);
                last_d = rq[0].d;
                last_k = rq[0].known;
                rq.delete(0);
            end else begin
                chk("mon_rd_valid", app_rd_data_valid, 1'b0);
            end
            chk("mon_rd_end", app_rd_data_end, app_rd_data_valid);
            if (last_k) chk("mon_rd_data", app_rd_data, last_d);
            chk("mon_calib", init_calib_complete, calib_m);
            chk("mon_app_rdy", app_rdy, rdy_m);
            chk("mon_wdf_rdy", app_wdf_rdy, wrdy_m);
            chk("mon_err", err_o, err_m);
        end
        if (rst) begin
            since_rel = 0; pend_m = 0; err_m = 0;
            wq.delete(); rq.delete();
            last_d = '0; last_k = 1; armed = 1;
        end else if (armed) begin
            push = app_wdf_wren && wrdy_m;
            acc  = app_en && rdy_m;
            idx  = int'(app_addr[12:3]);
            if ((app_wdf_wren && !wrdy_m) || (app_wdf_wren != app_wdf_end) || (acc && app_cmd > 3'd1))
                err_m = 1;
            if (push) wq.push_back('{app_wdf_data, app_wdf_mask});
            if (acc && app_cmd == 3'd0) begin
                if (wq.size() > 0) model_commit(idx);
                else begin pend_m = 1; pend_idx_m = idx; end
            end else if (pend_m && wq.size() > 0) begin
                model_commit(pend_idx_m);
                pend_m = 0;
            end
            if (acc && app_cmd == 3'd1) begin
                r.due = cyc + L; r.d = mem_m[idx]; r.known = known_m[idx];
                rq.push_back(r);
            end
            since_rel++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        app_en = 0; app_cmd = 0; app_wdf_wren = 0; app_wdf_end = 0; app_wdf_mask = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    task automatic wait_calib(output int n);
        n = 0;
        while (!init_calib_complete && n < 200) begin tick(); n++; end
    endtask

    task automatic send_cmd(input logic [2:0] cmd, input logic [ADDR_W-1:0] addr, output int acc_cyc);
        bit done = 0;
        app_en = 1; app_cmd = cmd; app_addr = addr; acc_cyc = -1;
        for (int k = 0; k < 50 && !done; k++) begin
            done = app_rdy;
            acc_cyc = cyc;
            tick();
        end
        app_en = 0;
        if (!done) chk("cmd_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic send_data(input logic [127:0] d, input logic [15:0] m);
        bit done = 0;
        app_wdf_wren = 1; app_wdf_end = 1; app_wdf_data = d; app_wdf_mask = m;
        for (int k = 0; k < 50 && !done; k++) begin
            done = app_wdf_rdy;
            tick();
        end
        app_wdf_wren = 0; app_wdf_end = 0;
        if (!done) chk("wdf_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic read_check(input logic [ADDR_W-1:0] addr, input logic [127:0] exp, input string nm);
        int ac;
        bit seen = 0;
        send_cmd(3'd1, addr, ac);
        for (int k = 0; k < L + 3 && !seen; k++) begin
            if (app_rd_data_valid) begin
                seen = 1;
                chk({nm, "_latency"}, 128'(cyc - ac), 128'(L));
                chk({nm, "_data"}, app_rd_data, exp);
            end else tick();
        end
        if (!seen) chk({nm, "_valid_timeout"}, 1'b0, 1'b1);
    endtask

    typedef struct {
        logic [ADDR_W-1:0] waddr;
        logic [ADDR_W-1:0] raddr;
        logic [127:0]      init;
        logic [127:0]      wdata;
        logic [15:0]       mask;
        logic [127:0]      exp;
    } vec_t;

    vec_t tbl[6];
    logic [127:0] beat [16];
    logic [127:0] got[$];

    initial begin
        int n, ac, accepted, nvalid;
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ac, accepted, nvalid;
        logic [127:0] d;
        tbl[0] = '{27'h20, 27'h20, {16{8'h11}}, {16{8'h22}}, 16'h00FF, {{8{8'h22}}, {8{8'h11}}}};
        tbl[1] = '{27'h28, 27'h28, {16{8'h33}}, {16{8'h44}}, 16'hFF00, {{8{8'h33}}, {8{8'h44}}}};
        tbl[2] = '{27'h30, 27'h30, 128'h0, {4{32'hDEADBEEF}}, 16'h0000, {4{32'hDEADBEEF}}};
        tbl[3] = '{27'h38, 27'h38, {16{8'h55}}, {16{8'hAA}}, 16'hFFFF, {16{8'h55}}};
        tbl[4] = '{27'h2048, 27'h48, {16{8'h66}}, {16{8'h77}}, 16'h0001, {{15{8'h77}}, 8'h66}};
        tbl[5] = '{27'h7FFE050, 27'h50, {16{8'h88}}, {16{8'h99}}, 16'h8000, {8'h88, {15{8'h99}}}};

        // Reset values and calibration timing
        do_reset();
        chk("rst_app_rdy", app_rdy, 1'b0);
        chk("rst_wdf_rdy", app_wdf_rdy, 1'b0);
        chk("rst_rd_valid", app_rd_data_valid, 1'b0);
        chk("rst_rd_data", app_rd_data, 128'h0);
        chk("rst_calib", init_calib_complete, 1'b0);
        chk("rst_err", err_o, 1'b0);
        wait_calib(n);
        chk("calib_cycles", 128'(n), 128'(CALIB));
        chk("calib_wdf_rdy", app_wdf_rdy, 1'b1);

        // Data before command, then read back
        send_data({16{8'hA5}}, 16'h0);
        send_cmd(3'd0, 27'h10, ac);
        read_check(27'h10, {16{8'hA5}}, "data_first");

        // Command before data: app_rdy held low while the write is pending
        send_cmd(3'd0, 27'h18, ac);
        for (int k = 0; k < 3; k++) begin
            chk("pend_rdy_low", app_rdy, 1'b0);
            tick();
        end
        send_data(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'h0);
        read_check(27'h18, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, "cmd_first");
        chk("no_err_yet", err_o, 1'b0);

        // Masked-write / aliasing vectors
        for (int i = 0; i < 6; i++) begin
            send_data(tbl[i].init, 16'h0);
            send_cmd(3'd0, tbl[i].waddr, ac);
            send_data(tbl[i].wdata, tbl[i].mask);
            send_cmd(3'd0, tbl[i].waddr, ac);
            read_check(tbl[i].raddr, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Before calibration: app_en leaves err clear, wren sets it
        do_reset();
        app_en = 1; app_cmd = 3'd0; app_addr = '0;
        for (int k = 0; k < 3; k++) tick();
        chk("precal_en_err", err_o, 1'b0);
        chk("precal_rdy", app_rdy, 1'b0);
        app_en = 0; app_wdf_wren = 1; app_wdf_end = 1;
        tick();
        app_wdf_wren = 0; app_wdf_end = 0;
        chk("precal_wren_err", err_o, 1'b1);

        // FIFO overflow, then four commands drain beats in order
        do_reset();
        wait_calib(n);
        chk("ovf_err_clear", err_o, 1'b0);
        for (int i = 0; i < 5; i++) begin
            app_wdf_wren = 1; app_wdf_end = 1; app_wdf_mask = '0;
            app_wdf_data = {4{32'hC0DE0000 + 32'(i)}};
            tick();
            if (i == 2) chk("ovf_rdy_after3", app_wdf_rdy, 1'b1);
            if (i == 3) chk("ovf_rdy_after4", app_wdf_rdy, 1'b0);
        end
        app_wdf_wren = 0; app_wdf_end = 0;
        chk("ovf_err", err_o, 1'b1);
        for (int i = 0; i < 4; i++) send_cmd(3'd0, ADDR_W'(27'h80 + 8 * i), ac);
        chk("ovf_drained_rdy", app_wdf_rdy, 1'b1);
        for (int i = 0; i < 4; i++)
            read_check(ADDR_W'(27'h80 + 8 * i), {4{32'hC0DE0000 + 32'(i)}}, $sformatf("drain%0d", i));

        // wren without end: flagged but the beat is still used
        do_reset();
        wait_calib(n);
        app_wdf_wren = 1; app_wdf_end = 0; app_wdf_data = {8{16'hBEEF}}; app_wdf_mask = '0;
        tick();
        app_wdf_wren = 0;
        chk("wren_end_err", err_o, 1'b1);
        send_cmd(3'd0, 27'h90, ac);
        read_check(27'h90, {8{16'hBEEF}}, "wren_end_beat");

        // Illegal command: accepted without memory effect, flagged
        do_reset();
        wait_calib(n);
        send_cmd(3'd2, 27'h90, ac);
        chk("illegal_cmd_err", err_o, 1'b1);
        read_check(27'h90, {8{16'hBEEF}}, "illegal_no_effect");

        // 16 back-to-back reads under periodic stall
        do_reset();
        wait_calib(n);
        for (int i = 0; i < 16; i++) begin
            beat[i] = {$urandom, $urandom, $urandom, $urandom};
            send_data(beat[i], 16'h0);
            send_cmd(3'd0, ADDR_W'(8 * i), ac);
        end
        got.delete();
        accepted = 0;
        app_en = 1; app_cmd = 3'd1; app_addr = '0;
        for (int k = 0; k < 100 && got.size() < 16; k++) begin
            bit r;
            r = app_rdy && (accepted < 16);
            if (accepted >= 16) app_en = 0;
            tick();
            if (r) begin accepted++; app_addr = ADDR_W'(8 * accepted); end
            if (app_rd_data_valid) got.push_back(app_rd_data);
        end
        app_en = 0;
        chk("burst_count", 128'(got.size()), 128'd16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            chk($sformatf("burst%0d", i), got[i], beat[i]);

        // Reset in the middle of a read burst: nothing more comes out
        accepted = 0;
        app_en = 1; app_cmd = 3'd1; app_addr = '0;
        for (int k = 0; k < 50 && accepted < 6; k++) begin
            bit r;
            r = app_rdy;
            tick();
            if (r) begin accepted++; app_addr = ADDR_W'(8 * accepted); end
        end
        rst = 1;
        tick();
        app_en = 0;
        nvalid = 0;
        for (int k = 0; k < L + 4; k++) begin
            if (k == 1) rst = 0;
            if (app_rd_data_valid) nvalid++;
            tick();
        end
        chk("midburst_reset_valids", 128'(nvalid), 128'd0);

        // Random traffic against the model
        do_reset();
        wait_calib(n);
        for (int k = 0; k < 1500; k++) begin
            app_wdf_wren = ($urandom % 3) == 0;
            app_wdf_end  = app_wdf_wren ^ (($urandom % 60) == 0);
            app_wdf_data = {$urandom, $urandom, $urandom, $urandom};
            app_wdf_mask = ($urandom % 2) ? 16'h0 : 16'($urandom);
            app_en       = $urandom % 2;
            app_cmd      = (($urandom % 100) == 0) ? 3'(2 + $urandom % 6) : 3'($urandom % 2);
            d            = 128'($urandom);
            app_addr     = d[ADDR_W-1:0];
            app_addr[12:8] = '0;
            tick();
        end
        idle();
        for (int k = 0; k < L + 4; k++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
